decoder3to8_skid: RTL and testbench
===================================

DECODER3TO8_SKID -- requirements
Module: decoder3to8_skid

Interface
REQ-001 Parameter ACTIVE_LOW, default 0: output polarity; 0 = selected line 1, others 0; 1 = selected line 0, others 1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream presents a code on in.
REQ-005 in_ready  output  1  block can accept a code this cycle.
REQ-006 in  input  3  binary code 0..7 to be decoded.
REQ-007 out_valid  output  1  out holds a valid one-hot word.
REQ-008 out_ready  input  1  downstream accepts out this cycle.
REQ-009 out  output  8  decoded word; bit k selected for code k.
REQ-010 dec_cnt  output  8  count of completed output handshakes, wrapping.

Function
REQ-011 Input handshake: a code SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-012 Output handshake: a word SHALL be consumed on a rising edge where out_valid=1 and out_ready=1.
REQ-013 Storage: two code registers (main, skid), each with a valid flag; occupancy states EMPTY, ONE, TWO.
REQ-014 in_ready SHALL equal NOT skid_valid, driven from a register only (no combinational path from out_ready).
REQ-015 out_valid SHALL equal main_valid; out SHALL be the one-hot decode of the main code, polarity per ACTIVE_LOW.
REQ-016 When out_valid=0, out SHALL be 8'h00 (ACTIVE_LOW=0) or 8'hFF (ACTIVE_LOW=1).
REQ-017 Latency: a code accepted on edge N SHALL appear on out with out_valid=1 after edge N when the block was EMPTY.
REQ-018 EMPTY + accept -> ONE (code into main).
REQ-019 ONE + accept, no consume -> TWO (code into skid); ONE + consume, no accept -> EMPTY.
REQ-020 ONE + accept + consume on the same edge -> ONE with the new code in main.
REQ-021 TWO + consume -> ONE with the skid code moved into main; no accept is possible in TWO.
REQ-022 Order SHALL be preserved; no code SHALL be dropped or duplicated.
REQ-023 out SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 in values with in_valid=0 SHALL be ignored and SHALL NOT alter state.
REQ-025 dec_cnt SHALL increment by 1 on each output handshake and wrap from 255 to 0.
REQ-026 Throughput: with out_ready held at 1, the block SHALL sustain one code per cycle.

Reset
REQ-027 While rst_n=0: main_valid=0, skid_valid=0, out_valid=0, in_ready=1, dec_cnt=0, out=8'h00 (8'hFF if ACTIVE_LOW).
REQ-028 Reset asserted mid-operation SHALL discard all held codes immediately, without waiting for a clock edge.
REQ-029 After rst_n deassertion, the first rising edge SHALL be able to accept a code.

Verification
REQ-030 Reset release, then in=3 with in_valid=1 for one cycle and out_ready=1 -> next cycle out=8'h08, out_valid=1; following cycle out_valid=0 and dec_cnt=1.
REQ-031 Stall: out_ready=0; send codes 5, then 2 -> out=8'h20 held, in_ready=0 after the second accept; raise out_ready -> out=8'h20, then 8'h04, then in_ready=1.
REQ-032 Streaming: codes 0..7 on consecutive cycles with out_ready=1 -> out = 01,02,04,...,80 on consecutive cycles, no bubbles, dec_cnt=8.
REQ-033 ACTIVE_LOW=1: code 6 -> out=8'hBF; idle -> out=8'hFF.
REQ-034 TWO state, then assert rst_n=0 asynchronously between edges -> out_valid=0, in_ready=1, and dec_cnt=0 at once; no stale code after release.
REQ-035 Run 256 handshakes -> dec_cnt wraps to 0; random valid/ready bench checked against a reference queue with no loss, duplication or reordering.

Source files
------------

// File: rtl/decoder3to8_skid.sv
// ---------------------------------------------------------------------------
// decoder3to8_skid
//
// Registered 3-to-8 one-hot decoder with a two-entry (main + skid) buffer on
// a valid/ready stream. A code accepted on the input shows up decoded on the
// output after one clock edge when the buffer was empty. With out_ready held
// high the block streams one code per cycle. in_ready comes from the skid
// occupancy register only, so there is no combinational path from out_ready
// to in_ready.
//
// Parameters
//   ACTIVE_LOW  0: selected bit is 1 and the others are 0
//               1: selected bit is 0 and the others are 1
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream presents a code on in
//   in_ready   out  block can take a code this cycle
//   in[2:0]    in   binary code to decode
//   out_valid  out  out holds a valid decoded word
//   out_ready  in   downstream takes out this cycle
//   out[7:0]   out  decoded word; idle value is all-inactive
//   dec_cnt    out  completed output handshakes, wraps at 256
// ---------------------------------------------------------------------------
module decoder3to8_skid #(
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out,
   output logic [7:0] dec_cnt
);

   // Buffer occupancy. main is valid in ONE and TWO; skid is valid in TWO only.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;

   occ_t       state_reg, state_next;
   logic [2:0] main_code_reg, main_code_next;
   logic [2:0] skid_code_reg, skid_code_next;
   logic [7:0] dec_cnt_reg, dec_cnt_next;

   logic       main_valid;
   logic       skid_valid;
   logic       accept;
   logic       consume;
   logic [7:0] onehot;

   assign main_valid = (state_reg == ONE) || (state_reg == TWO);
   assign skid_valid = (state_reg == TWO);

   assign in_ready  = ~skid_valid;
   assign out_valid = main_valid;

   assign accept  = in_valid & in_ready;
   assign consume = main_valid & out_ready;

   // -----------------------------------------------------------------------
   // State and data registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= EMPTY;
         main_code_reg <= 3'd0;
         skid_code_reg <= 3'd0;
         dec_cnt_reg   <= 8'd0;
      end else begin
         state_reg     <= state_next;
         main_code_reg <= main_code_next;
         skid_code_reg <= skid_code_next;
         dec_cnt_reg   <= dec_cnt_next;
      end
   end

   // -----------------------------------------------------------------------
   // Next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      main_code_next = main_code_reg;
      skid_code_next = skid_code_reg;
      dec_cnt_next   = consume ? (dec_cnt_reg + 8'd1) : dec_cnt_reg;

      case (state_reg)
         EMPTY: begin
            if (accept) begin
               state_next     = ONE;
               main_code_next = in;
            end
         end
         ONE: begin
            if (accept && consume) begin
               // Pass-through: the new code replaces the one leaving.
               main_code_next = in;
            end else if (accept) begin
               state_next     = TWO;
               skid_code_next = in;
            end else if (consume) begin
               state_next     = EMPTY;
            end
         end
         TWO: begin
            // in_ready is low here, so only a consume can happen.
            if (consume) begin
               state_next     = ONE;
               main_code_next = skid_code_reg;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // Output decode. Gating with main_valid makes the idle word all-inactive,
   // and because state_reg clears asynchronously the output drops at once
   // when reset asserts.
   // -----------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_dec
         assign onehot[gi] = main_valid && (main_code_reg == 3'(gi));
      end
   endgenerate

   assign out     = ACTIVE_LOW ? ~onehot : onehot;
   assign dec_cnt = dec_cnt_reg;

endmodule

// File: tb/tb_decoder3to8_skid.sv
// ---------------------------------------------------------------------------
// tb_decoder3to8_skid
//
// Self-checking bench for decoder3to8_skid. Accepted codes are pushed to a
// reference queue and popped and compared when the output handshake fires.
// Directed sequences cover single transfer, stall/skid, streaming,
// active-low polarity, asynchronous reset in the TWO state, and counter wrap.
// A random valid/ready phase ends the run.
// ---------------------------------------------------------------------------
module tb_decoder3to8_skid;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out;
   logic [7:0] dec_cnt;

   logic       a_in_valid;
   logic       a_in_ready;
   logic [2:0] a_in;
   logic       a_out_valid;
   logic       a_out_ready;
   logic [7:0] a_out;
   logic [7:0] a_dec_cnt;

   int         n_vec;
   int         n_err;
   logic [2:0] exp_q[$];
   logic [7:0] dec_model;

   typedef struct {
      logic [2:0] code;
      logic [7:0] word;
   } vec_t;

   vec_t tbl[8];

   decoder3to8_skid #(.ACTIVE_LOW(1'b0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .dec_cnt   (dec_cnt)
   );

   decoder3to8_skid #(.ACTIVE_LOW(1'b1)) dut_al (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in        (a_in),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out       (a_out),
      .dec_cnt   (a_dec_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end else begin
         $display("ok   %s: %02h", name, act);
      end
   endtask

   // One clock cycle, starting and ending at a falling edge. Inputs are driven,
   // allowed to settle, and the handshakes that the next rising edge will
   // perform are recorded against the reference queue.
   task automatic step(input logic v, input logic [2:0] c, input logic r);
      logic [7:0] e;
      in_valid  = v;
      in        = c;
      out_ready = r;
      #1;
      if (out_valid && out_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL consume: got word %02h expected none (queue empty)", out);
         end else begin
            e = 8'h01 << exp_q[0];
            void'(exp_q.pop_front());
            if (out !== e) begin
               n_err++;
               $display("FAIL consume: got %02h expected %02h", out, e);
            end else begin
               $display("ok   consume: %02h", out);
            end
         end
         dec_model = dec_model + 8'd1;
      end
      if (in_valid && in_ready) exp_q.push_back(in);
      @(negedge clk);
   endtask

   initial begin
      n_vec       = 0;
      n_err       = 0;
      dec_model   = 8'd0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in          = 3'd0;
      out_ready   = 1'b0;
      a_in_valid  = 1'b0;
      a_in        = 3'd0;
      a_out_ready = 1'b1;

      tbl[0] = '{3'd0, 8'h01};
      tbl[1] = '{3'd1, 8'h02};
      tbl[2] = '{3'd2, 8'h04};
      tbl[3] = '{3'd3, 8'h08};
      tbl[4] = '{3'd4, 8'h10};
      tbl[5] = '{3'd5, 8'h20};
      tbl[6] = '{3'd6, 8'h40};
      tbl[7] = '{3'd7, 8'h80};

      // Reset state
      #3;
      chk("rst out_valid", {7'd0, out_valid}, 8'h00);
      chk("rst in_ready",  {7'd0, in_ready},  8'h01);
      chk("rst out",       out,               8'h00);
      chk("rst dec_cnt",   dec_cnt,           8'h00);
      chk("rst al out",    a_out,             8'hFF);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Single transfer, code 3
      step(1'b1, 3'd3, 1'b1);
      chk("single out",       out,               8'h08);
      chk("single out_valid", {7'd0, out_valid}, 8'h01);
      step(1'b0, 3'd0, 1'b1);
      chk("single idle valid", {7'd0, out_valid}, 8'h00);
      chk("single dec_cnt",    dec_cnt,           8'h01);

      // Stall: 5 then 2 with out_ready low; idle in values are ignored
      step(1'b1, 3'd5, 1'b0);
      chk("stall out1",     out,              8'h20);
      chk("stall in_ready1", {7'd0, in_ready}, 8'h01);
      step(1'b1, 3'd2, 1'b0);
      chk("stall out2",     out,              8'h20);
      chk("stall in_ready2", {7'd0, in_ready}, 8'h00);
      step(1'b0, 3'd7, 1'b0);
      chk("stall hold",     out,              8'h20);
      step(1'b0, 3'd7, 1'b1);
      chk("stall out3",     out,              8'h04);
      chk("stall in_ready3", {7'd0, in_ready}, 8'h01);
      step(1'b0, 3'd0, 1'b1);
      chk("stall drained",  {7'd0, out_valid}, 8'h00);
      chk("stall dec_cnt",  dec_cnt,           8'h03);

      // Streaming 0..7 back to back
      for (int i = 0; i < 8; i++) begin
         step(1'b1, tbl[i].code, 1'b1);
         chk($sformatf("stream out[%0d]", i), out, tbl[i].word);
         chk($sformatf("stream vld[%0d]", i), {7'd0, out_valid}, 8'h01);
      end
      step(1'b0, 3'd0, 1'b1);
      chk("stream dec_cnt", dec_cnt, 8'd11);

      // Active-low polarity, code 6
      a_in_valid = 1'b1;
      a_in       = 3'd6;
      step(1'b0, 3'd0, 1'b1);
      a_in_valid = 1'b0;
      chk("al out code6", a_out, 8'hBF);
      step(1'b0, 3'd0, 1'b1);
      chk("al out idle", a_out, 8'hFF);

      // Fill to TWO, then reset between edges
      step(1'b1, 3'd1, 1'b0);
      step(1'b1, 3'd4, 1'b0);
      chk("two in_ready", {7'd0, in_ready}, 8'h00);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst out_valid", {7'd0, out_valid}, 8'h00);
      chk("arst in_ready",  {7'd0, in_ready},  8'h01);
      chk("arst dec_cnt",   dec_cnt,           8'h00);
      chk("arst out",       out,               8'h00);
      exp_q.delete();
      dec_model = 8'd0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 3'd0, 1'b1);
      step(1'b0, 3'd0, 1'b1);
      chk("post-rst no stale", {7'd0, out_valid}, 8'h00);

      // First edge after release accepts immediately
      step(1'b1, 3'd7, 1'b1);
      chk("post-rst accept", out, 8'h80);
      step(1'b0, 3'd0, 1'b1);

      // Counter wrap: 255 handshakes after this reset, then one more
      for (int i = 0; i < 254; i++) step(1'b1, 3'($urandom_range(0, 7)), 1'b1);
      step(1'b0, 3'd0, 1'b1);
      chk("cnt 255", dec_cnt, 8'd255);
      step(1'b1, 3'd2, 1'b1);
      step(1'b0, 3'd0, 1'b1);
      chk("cnt wrap", dec_cnt, 8'd0);

      // Random valid/ready
      for (int i = 0; i < 600; i++)
         step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
      for (int i = 0; i < 6 && (exp_q.size() != 0 || out_valid); i++)
         step(1'b0, 3'd0, 1'b1);
      chk("rand queue empty", 8'(exp_q.size()), 8'd0);
      chk("rand out_valid",   {7'd0, out_valid}, 8'h00);
      chk("rand dec_cnt",     dec_cnt,           dec_model);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
